// File: rtl/mux_rr_pipe_pkg.sv
// mux_pkg: shared mode encoding and counter width for mux_rr_pipe
package mux_pkg;
   typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mux_mode_e;
   localparam int GNT_CNT_W = 16;
endpackage

// File: rtl/mux_rr_pipe_if.sv
// mux_rr_pipe_if: channel/output handshake bundle; gnt_cnt exists only with MUX_GNT_CNT_EN
interface mux_rr_pipe_if
   import mux_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int W    = 4
);
   localparam int SEL_W = $clog2(N_CH);
   logic                en;
   mux_mode_e           mode;
   logic [SEL_W-1:0]    sel;
   logic [N_CH*W-1:0]   in_data;
   logic [N_CH-1:0]     in_valid;
   logic [N_CH-1:0]     in_ready;
   logic [W-1:0]        y;
   logic [SEL_W-1:0]    y_ch;
   logic                y_valid;
   logic                y_ready;
`ifdef MUX_GNT_CNT_EN
   logic [N_CH*GNT_CNT_W-1:0] gnt_cnt;
`endif
   modport master (
      output en, mode, sel, in_data, in_valid, y_ready,
      input  in_ready, y, y_ch, y_valid
`ifdef MUX_GNT_CNT_EN
      , input gnt_cnt
`endif
   );
   modport slave (
      input  en, mode, sel, in_data, in_valid, y_ready,
      output in_ready, y, y_ch, y_valid
`ifdef MUX_GNT_CNT_EN
      , output gnt_cnt
`endif
   );
endinterface

// File: rtl/mux_rr_pipe_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from ptr+1 with wrap
module rr_arbiter #(
   parameter  int N_CH  = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_CH-1:0]  gnt_onehot,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             any_gnt
);
   logic [SEL_W-1:0] c;
   // farthest candidate first so the nearest requester after ptr overwrites it
   always_comb begin
      c       = '0;
      gnt_idx = '0;
      any_gnt = 1'b0;
      for (int k = N_CH; k >= 1; k--) begin
         c = SEL_W'((int'(ptr) + k) % N_CH);
         if (req[c]) begin
            gnt_idx = c;
            any_gnt = 1'b1;
         end
      end
   end
   assign gnt_onehot = any_gnt ? N_CH'(1) << gnt_idx : '0;
endmodule

// File: rtl/mux_rr_pipe.sv
// mux_rr_pipe: N-channel registered mux, fixed/round-robin select; MUX_GNT_CNT_EN adds per-channel grant counters
module mux_rr_pipe
   import mux_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int W    = 4
) (
   input logic         clk,
   input logic         rst,
   mux_rr_pipe_if.slave bus
);
   localparam int SEL_W = $clog2(N_CH);
   logic [W-1:0]     y_q;
   logic [SEL_W-1:0] y_ch_q;
   logic             y_valid_q;
   logic [SEL_W-1:0] rr_ptr;
   logic [N_CH-1:0]  gnt_onehot;
   logic [SEL_W-1:0] gnt_idx;
   logic             any_gnt;
   logic             load_ok;
   logic [N_CH-1:0]  fixed_rdy;
   logic [SEL_W-1:0] idx;
   logic             xfer;
   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .req        (bus.in_valid),
      .ptr        (rr_ptr),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any_gnt    (any_gnt)
   );
   assign load_ok      = bus.en & (~y_valid_q | bus.y_ready);
   assign fixed_rdy    = int'(bus.sel) < N_CH ? {{(N_CH-1){1'b0}}, load_ok} << bus.sel : '0;
   assign bus.in_ready = bus.mode == MODE_RR ? gnt_onehot & {N_CH{load_ok & any_gnt}} : fixed_rdy;
   assign idx          = bus.mode == MODE_RR ? gnt_idx : bus.sel;
   assign xfer         = |(bus.in_valid & bus.in_ready);
   always_ff @(posedge clk) begin
      if (rst) begin
         y_q       <= '0;
         y_ch_q    <= '0;
         y_valid_q <= 1'b0;
         rr_ptr    <= SEL_W'(N_CH - 1);
      end else if (xfer) begin
         y_q       <= bus.in_data[int'(idx)*W +: W];
         y_ch_q    <= idx;
         y_valid_q <= 1'b1;
         if (bus.mode == MODE_RR) rr_ptr <= idx;
      end else if (y_valid_q && bus.y_ready) begin
         y_q       <= '0;
         y_ch_q    <= '0;
         y_valid_q <= 1'b0;
      end
   end
   assign bus.y       = y_q;
   assign bus.y_ch    = y_ch_q;
   assign bus.y_valid = y_valid_q;
`ifdef MUX_GNT_CNT_EN
   logic [GNT_CNT_W-1:0] cnt [N_CH];
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_CH; i++)
         cnt[i] <= rst ? '0 : cnt[i] + GNT_CNT_W'(xfer && int'(idx) == i);
   end
   for (genvar g = 0; g < N_CH; g++) begin : g_cnt
      assign bus.gnt_cnt[g*GNT_CNT_W +: GNT_CNT_W] = cnt[g];
   end
`endif
endmodule

// File: tb/tb_mux_rr_pipe.sv
// tb_mux_rr_pipe: directed + random checks of mux_rr_pipe against a behavioural model
module tb_mux_rr_pipe;
   import mux_pkg::*;
   localparam int N = 4;
   localparam int W = 4;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   logic [W-1:0]  m_y;
   int            m_ch;
   logic          m_v;
   int            m_last;
   int            m_cnt [N];
   mux_rr_pipe_if #(.N_CH(N), .W(W)) bus ();
   mux_rr_pipe #(.N_CH(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // which channel the spec says may transfer now; -1 if none is ready
   function automatic int model_pick();
      if (!bus.en || (m_v && !bus.y_ready)) return -1;
      if (bus.mode == MODE_FIXED) return int'(bus.sel) < N ? int'(bus.sel) : -1;
      for (int k = 1; k <= N; k++)
         if (bus.in_valid[(m_last + k) % N]) return (m_last + k) % N;
      return -1;
   endfunction

   task automatic tick();
      int p;
      logic [N-1:0] rdy;
      logic [W-1:0] d;
      #1;
      p   = model_pick();
      rdy = p >= 0 ? N'(1) << p : '0;
      chk("in_ready", 64'(bus.in_ready), 64'(rdy));
      d = p >= 0 ? bus.in_data[p*W +: W] : '0;
      @(posedge clk);
      if (rst) begin
         m_y = '0; m_ch = 0; m_v = 1'b0; m_last = N - 1;
         for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (p >= 0 && bus.in_valid[p]) begin
         m_y = d; m_ch = p; m_v = 1'b1;
         if (bus.mode == MODE_RR) m_last = p;
         m_cnt[p] = (m_cnt[p] + 1) % 65536;
      end else if (m_v && bus.y_ready) begin
         m_y = '0; m_ch = 0; m_v = 1'b0;
      end
      @(negedge clk);
      chk("y", 64'(bus.y), 64'(m_y));
      chk("y_ch", 64'(bus.y_ch), 64'(m_ch));
      chk("y_valid", 64'(bus.y_valid), 64'(m_v));
`ifdef MUX_GNT_CNT_EN
      for (int i = 0; i < N; i++) chk("gnt_cnt", 64'(bus.gnt_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
   endtask

   initial begin
      m_y = '0; m_ch = 0; m_v = 1'b0; m_last = N - 1;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      rst = 1'b1; bus.en = 1'b0; bus.mode = MODE_FIXED; bus.sel = '0;
      bus.in_valid = '1; bus.in_data = 16'h4321; bus.y_ready = 1'b1;
      tick(); tick();
      chk("reset_y_valid", 64'(bus.y_valid), 64'd0);
      chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
      // fixed select on channel 2
      rst = 1'b0; bus.en = 1'b1; bus.sel = 2'd2; bus.in_data = 16'h3A10;
      tick();
      chk("fixed_y", 64'(bus.y), 64'hA);
      chk("fixed_ch", 64'(bus.y_ch), 64'd2);
      tick(); tick();
      // round robin, all valid: 0,1,2,3,0
      bus.mode = MODE_RR;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rr_seq", 64'(bus.y_ch), 64'(i % N));
      end
      // backpressure on a channel 1 word
      bus.mode = MODE_FIXED; bus.sel = 2'd1; bus.in_data = 16'h0050;
      tick();
      bus.y_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_y", 64'(bus.y), 64'h5);
         chk("bp_ch", 64'(bus.y_ch), 64'd1);
      end
      bus.y_ready = 1'b1; bus.in_valid = '0;
      tick();
      chk("bp_release", 64'(bus.y_valid), 64'd0);
      // enable low drains the held word
      bus.in_valid = '1;
      tick();
      bus.en = 1'b0;
      tick();
      chk("drain_valid", 64'(bus.y_valid), 64'd0);
      chk("drain_y", 64'(bus.y), 64'd0);
      tick();
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rst          = $urandom_range(0, 39) == 0;
         bus.en       = $urandom_range(0, 7) != 0;
         bus.mode     = mux_mode_e'($urandom_range(0, 1));
         bus.sel      = 2'($urandom_range(0, N - 1));
         bus.in_valid = N'($urandom);
         bus.in_data  = (N*W)'($urandom);
         bus.y_ready  = $urandom_range(0, 3) != 0;
         tick();
      end
`ifdef MUX_GNT_CNT_EN
      rst = 1'b1;
      tick();
      rst = 1'b0; bus.en = 1'b1; bus.mode = MODE_FIXED; bus.sel = 2'd3;
      bus.in_valid = 4'b1000; bus.y_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk("cnt_five", 64'(bus.gnt_cnt), {16'd5, 48'd0});
      for (int i = 0; i < 65531; i++) tick();
      chk("cnt_wrap", 64'(bus.gnt_cnt), 64'd0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
